// File: rtl/vlsi_pkg.sv
// Shared types and helpers for the serial transmitter slice.
// State encodings and a width helper.
package vlsi_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } tx_state_e;

  // Ceiling log2, evaluated at elaboration for counter widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Load/shift register for the serial transmitter.
// sout is the bit to be launched on the coming edge.
module piso_shreg
  import vlsi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] din_adv;
  logic [WIDTH-1:0] sh_adv;

  // The first bit leaves straight from din, so the
  // register keeps the word already advanced by one.
  always_comb begin
    if (MSB_FIRST) begin
      din_adv = {din[WIDTH-2:0], 1'b0};
      sh_adv  = {sh_q[WIDTH-2:0], 1'b0};
      sout    = load ? din[WIDTH-1] : sh_q[WIDTH-1];
    end else begin
      din_adv = {1'b0, din[WIDTH-1:1]};
      sh_adv  = {1'b0, sh_q[WIDTH-1:1]};
      sout    = load ? din[0] : sh_q[0];
    end
    sh_d = sh_q;
    if (load) begin
      sh_d = din_adv;
    end else if (shift) begin
      sh_d = sh_adv;
    end
  end

  // Shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter with valid/ready input.
// All serial outputs come straight from flops.
module piso_serial_tx
  import vlsi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             tx_done
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rdy_en_q, rdy_en_d;
  logic ser_out_q, ser_out_d;
  logic ser_frame_q, ser_frame_d;
  logic tx_done_q, tx_done_d;

  logic last;
  logic accept;
  logic shift;
  logic sout;

  assign last     = (state_q == S_SHIFT) && (cnt_q == '0);
  assign tx_ready = rdy_en_q & ((state_q == S_IDLE) | last);
  assign accept   = tx_valid & tx_ready;
  assign shift    = (state_q == S_SHIFT) & ~last;

  piso_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .shift(shift),
    .din  (tx_data),
    .sout (sout)
  );

  // Next state, bit counter and next-cycle output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdy_en_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = CNT_TOP;
        end
      end
      S_SHIFT: begin
        if (!last) begin
          cnt_d = cnt_q - 1'b1;
        end else if (accept) begin
          cnt_d = CNT_TOP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    ser_frame_d = (state_d == S_SHIFT);
    ser_out_d   = ser_frame_d ? sout : IDLE_LVL;
    tx_done_d   = ser_frame_d && (cnt_d == '0);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
      ser_out_q   <= IDLE_LVL;
      ser_frame_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdy_en_q    <= rdy_en_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_frame = ser_frame_q;
  assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: MSB-first and LSB-first
// instances against a bit-queue model.
module tb_piso_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  logic rdy_m, out_m, frm_m, done_m;
  logic rdy_l, out_l, frm_l, done_l;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_m), .ser_out(out_m), .ser_frame(frm_m), .tx_done(done_m)
  );

  piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_l), .ser_out(out_l), .ser_frame(frm_l), .tx_done(done_l)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: every accepted word becomes 8 queued bit slots
  // {last, lsb-first bit, msb-first bit}; one slot per clock.
  logic [2:0] q[$];
  logic [2:0] cur = 3'b000;
  bit cur_v = 1'b0;
  bit m_rdy = 1'b0;
  bit chk_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur_v = 1'b0;
      m_rdy = 1'b0;
    end else begin
      if (tx_valid && m_rdy && q.size() == 0) begin
        for (int i = 0; i < 8; i++)
          q.push_back({i == 7, tx_data[i], tx_data[7-i]});
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
        cur_v = 1'b1;
      end else begin
        cur_v = 1'b0;
      end
      m_rdy = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("frame_m", frm_m, cur_v);
      chk("frame_l", frm_l, cur_v);
      chk("out_m", out_m, cur_v ? cur[0] : 1'b0);
      chk("out_l", out_l, cur_v ? cur[1] : 1'b0);
      chk("done_m", done_m, cur_v & cur[2]);
      chk("done_l", done_l, cur_v & cur[2]);
      chk("ready_m", rdy_m, m_rdy && q.size() == 0);
      chk("ready_l", rdy_l, m_rdy && q.size() == 0);
    end
  end

  // Capture of framed bits for literal checks.
  logic [31:0] cap_m = '0;
  logic [31:0] cap_l = '0;
  int nfrm = 0;
  int ndone = 0;

  always @(negedge clk) begin
    if (frm_m) begin
      cap_m = {cap_m[30:0], out_m};
      cap_l = {cap_l[30:0], out_l};
      nfrm++;
    end
    if (done_m) ndone++;
  end

  task automatic clr_cap();
    cap_m = '0;
    cap_l = '0;
    nfrm = 0;
    ndone = 0;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy_m) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", rdy_m, 1'b0);
    @(posedge clk);
    #1;

    // Long idle after reset.
    clr_cap();
    idle(20);
    chk("t6_frames", nfrm, 0);
    chk("t6_dones", ndone, 0);
    chk("t6_ready", rdy_m, 1'b1);

    // Single word, first bit one cycle after accept.
    clr_cap();
    send(8'hA5);
    chk("t1_lat_frame", frm_m, 1'b1);
    chk("t1_lat_bit", out_m, 1'b1);
    idle(10);
    chk("t1_bits_m", cap_m[7:0], 8'hA5);
    chk("t1_bits_l", cap_l[7:0], 8'hA5);
    chk("t1_frames", nfrm, 8);
    chk("t1_dones", ndone, 1);

    // Back-to-back words with valid held.
    clr_cap();
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 tx_data = 8'h3C;
    wait_ready();
    @(posedge clk);
    #1 tx_valid = 1'b0;
    idle(12);
    chk("t2_bits_m", cap_m[15:0], 16'hA53C);
    chk("t2_bits_l", cap_l[15:0], 16'hA53C);
    chk("t2_frames", nfrm, 16);
    chk("t2_dones", ndone, 2);

    // Bit order.
    clr_cap();
    send(8'h01);
    idle(10);
    chk("t3_bits_m", cap_m[7:0], 8'h01);
    chk("t3_bits_l", cap_l[7:0], 8'h80);
    chk("t3_dones", ndone, 1);

    // Input churn during shifting is ignored.
    clr_cap();
    send(8'hF0);
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'h0F;
      tx_valid = i[0];
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    idle(10);
    chk("t4_bits_m", cap_m[7:0], 8'hF0);
    chk("t4_bits_l", cap_l[7:0], 8'h0F);
    chk("t4_frames", nfrm, 8);

    // Reset during the 4th bit.
    clr_cap();
    send(8'hA5);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_frame", frm_m, 1'b0);
    chk("t5_out", out_m, 1'b0);
    chk("t5_ready", rdy_m, 1'b0);
    chk("t5_done", done_m, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("t5_ready_rel", rdy_m, 1'b0);
    @(posedge clk);
    #1 chk("t5_ready_set", rdy_m, 1'b1);
    chk("t5_no_done", ndone, 0);
    clr_cap();
    send(8'hFF);
    idle(10);
    chk("t5_bits_m", cap_m[7:0], 8'hFF);
    chk("t5_frames", nfrm, 8);
    chk("t5_dones", ndone, 1);

    // Random traffic.
    repeat (3000) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
